pwm_multi_channel: RTL and testbench
====================================

Name: pwm_multi_channel

Overview:
- Parametrised multi-channel PWM generator; next generation of the single-channel PWM.
- CHANNELS outputs share one period counter and a programmable prescaler.
- Per-channel duty uses double-buffering: new values take effect only at a period boundary.
- Supports edge-aligned and center-aligned modes, and a graceful stop that finishes the current period.
- Sits between the register/control logic and the output pins.

Parameters:
- WORD_LENGTH, 8: duty and period counter width; MAX = 2^WORD_LENGTH-1.
- FREQ_LENGTH, 2: prescaler select width; divide ratio is 2^frequency.
- CHANNELS, 4: number of independent PWM outputs.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level run request; high = run, low = stop at end of current period.
- dutyCycle  in  CHANNELS*WORD_LENGTH  packed duties; channel i = bits [i*WORD_LENGTH +: WORD_LENGTH].
- frequency  in  FREQ_LENGTH  prescaler select.
- center_align  in  1  0 = edge-aligned, 1 = center-aligned.
- load  in  1  one-cycle strobe; captures dutyCycle, frequency and center_align into pending registers.
- pwm_output  out  CHANNELS  PWM outputs, registered.
- period_end  out  1  one-cycle pulse on the last clock of each period.
- busy  out  1  high while in RUN or DRAIN.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous, active-high and overrides everything, including mid-period.
  - Next edge after reset: state=IDLE; counter, prescaler and direction=up cleared; pending/active duty=0, frequency=0, mode=edge; pwm_output=0, period_end=0, busy=0.
- Pending/active registers:
  - load writes the pending registers.
  - Active registers copy pending on IDLE->RUN and at every period boundary.
  - load coinciding with a boundary: active takes the incoming port values directly (bypass).
- FSM, state IDLE/RUN/DRAIN (enum in package):
  - IDLE: start=1 -> RUN. Counter and prescaler cleared, active <- pending, busy=1 next cycle.
  - RUN: start=0 -> DRAIN.
  - DRAIN: start=1 -> RUN with no counter restart. Boundary -> IDLE.
  - IDLE outputs: pwm_output=0 and busy=0 from the cycle after the final boundary.
- Prescaler:
  - presc counts 0..2^f-1 with f = active frequency.
  - tick when presc == 2^f-1; f=0 ticks every cycle.
- Counter, advances only on tick:
  - Edge mode: 0..MAX then wraps to 0. Period = (MAX+1) ticks. Boundary = tick with cnt==MAX.
  - Center mode: 0 up to MAX, then down to 1, next period restarts at 0. Period = 2*MAX ticks. Boundary = tick, direction down, cnt==1.
- Output: pwm_output[i] <= busy_state && (cnt < duty_active[i]).
  - Registered, one clock after the counter value.
  - duty=0 -> constantly low.
  - Edge mode: high = duty ticks per period; duty=MAX -> high MAX of MAX+1 ticks.
  - Center mode: high = 2*duty-1 ticks (duty>=1), symmetric about cnt=0.
- period_end:
  - Asserted in the same cycle as the boundary tick, for exactly one clock.
  - Also fires on the DRAIN->IDLE boundary.
- Arithmetic: all comparisons unsigned WORD_LENGTH-bit; counter never exceeds MAX; no overflow.
- Mode/frequency changes: take effect only at a boundary; direction resets to up at every boundary.

Decomposition:
- Package pwm_pkg holds:
  - state_t enum {IDLE, RUN, DRAIN};
  - align_t enum {EDGE, CENTER};
  - default width constants.
- Sub-module pwm_prescaler (clk, reset, clear, frequency -> tick).
- Channel compare logic is a generate loop in the top level; no per-channel module.

Test Plan:
- Reset with start=1 held: during reset and one cycle after, pwm_output=0, busy=0, period_end=0; release -> busy=1 one cycle later.
- Edge mode, f=0, duties {ch0=15, ch1=0, ch2=255, ch3=128}:
  - per 256-cycle period, high counts are 15/0/255/128;
  - period_end pulses every 256 cycles.
- Same duties with f=1: period 512 cycles; ch0 high 30 consecutive cycles; period_end every 512.
- load ch0=64 mid-period: ch0 keeps 15-tick pulse until period_end, next period 64 high. Then load exactly on the boundary cycle: new value applies immediately.
- Center mode, f=0, ch0=10: period_end every 510 cycles; ch0 high 19 cycles per period, centered on the boundary.
- Stop and reset mid-run:
  - start dropped at cnt=100 -> outputs continue until period_end, then all 0 and busy=0.
  - start re-raised while in DRAIN -> no restart, counter continues.
  - reset pulsed at cnt=50 -> next cycle all outputs 0 and state IDLE.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the multi-channel PWM block.
package pwm_pkg;

    localparam int DEF_WORD_LENGTH = 8;
    localparam int DEF_FREQ_LENGTH = 2;
    localparam int DEF_CHANNELS    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef enum logic {
        EDGE   = 1'b0,
        CENTER = 1'b1
    } align_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Power-of-two clock prescaler: tick once every 2^frequency cycles.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int FREQ_LENGTH = DEF_FREQ_LENGTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [FREQ_LENGTH-1:0] frequency,
    output logic                   tick
);
    // Wide enough to hold 2^f-1 for the largest selectable f.
    localparam int PW = (2 ** FREQ_LENGTH) - 1;

    logic [PW-1:0] presc_q, presc_d, limit;

    always_comb begin
        limit = '0;
        for (int b = 0; b < PW; b++) begin
            limit[b] = (b < int'(frequency));
        end
        tick    = (presc_q == limit);
        presc_d = (clear || tick) ? '0 : presc_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: one shared period counter and prescaler, double-buffered
// per-channel duty, edge or center alignment, and a stop that drains the period.
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int WORD_LENGTH = DEF_WORD_LENGTH,
    parameter int FREQ_LENGTH = DEF_FREQ_LENGTH,
    parameter int CHANNELS    = DEF_CHANNELS
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [CHANNELS*WORD_LENGTH-1:0] dutyCycle,
    input  logic [FREQ_LENGTH-1:0]          frequency,
    input  logic                            center_align,
    input  logic                            load,
    output logic [CHANNELS-1:0]             pwm_output,
    output logic                            period_end,
    output logic                            busy,
    output state_t                          dbg_state
);
    localparam int                     DW      = CHANNELS * WORD_LENGTH;
    localparam logic [WORD_LENGTH-1:0] CNT_MAX = '1;
    localparam logic [WORD_LENGTH-1:0] CNT_ONE = WORD_LENGTH'(1);

    state_t                 state_q, state_d;
    logic [WORD_LENGTH-1:0] cnt_q, cnt_d;
    logic                   dir_down_q, dir_down_d;
    logic [DW-1:0]          pend_duty_q, pend_duty_d, act_duty_q, act_duty_d;
    logic [FREQ_LENGTH-1:0] pend_freq_q, pend_freq_d, act_freq_q, act_freq_d;
    align_t                 pend_align_q, pend_align_d, act_align_q, act_align_d;
    logic [CHANNELS-1:0]    pwm_q, pwm_d;
    logic                   running, tick, boundary, copy_active, final_boundary;
    align_t                 port_align;

    assign port_align = center_align ? CENTER : EDGE;
    assign running    = (state_q != IDLE);

    pwm_prescaler #(.FREQ_LENGTH(FREQ_LENGTH)) u_prescaler (
        .clk       (clk),
        .reset     (reset),
        .clear     (!running),
        .frequency (act_freq_q),
        .tick      (tick)
    );

    assign boundary = running && tick &&
                      ((act_align_q == EDGE) ? (cnt_q == CNT_MAX)
                                             : (dir_down_q && (cnt_q == CNT_ONE)));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (!start) state_d = boundary ? IDLE : DRAIN;
            DRAIN:   if (start) state_d = RUN;
                     else if (boundary) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        final_boundary = boundary && (state_d == IDLE);
        copy_active    = ((state_q == IDLE) && start) || boundary;
    end

    // load is a single-cycle strobe with no ready: it is always accepted. Active
    // copies pend_*_d rather than pend_*_q so a load on a boundary lands at once.
    always_comb begin
        pend_duty_d  = load ? dutyCycle  : pend_duty_q;
        pend_freq_d  = load ? frequency  : pend_freq_q;
        pend_align_d = load ? port_align : pend_align_q;
        act_duty_d   = copy_active ? pend_duty_d  : act_duty_q;
        act_freq_d   = copy_active ? pend_freq_d  : act_freq_q;
        act_align_d  = copy_active ? pend_align_d : act_align_q;
    end

    always_comb begin
        cnt_d      = cnt_q;
        dir_down_d = dir_down_q;
        if (!running || boundary) begin
            cnt_d      = '0;
            dir_down_d = 1'b0;
        end else if (tick) begin
            if (act_align_q == EDGE) begin
                cnt_d = cnt_q + CNT_ONE;
            end else if (!dir_down_q) begin
                if (cnt_q == CNT_MAX) begin
                    dir_down_d = 1'b1;
                    cnt_d      = cnt_q - CNT_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    // Outputs are forced low on the boundary that returns to IDLE.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        assign pwm_d[gi] = running && !final_boundary &&
                           (cnt_q < act_duty_q[gi*WORD_LENGTH +: WORD_LENGTH]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dir_down_q   <= 1'b0;
            pend_duty_q  <= '0;
            pend_freq_q  <= '0;
            pend_align_q <= EDGE;
            act_duty_q   <= '0;
            act_freq_q   <= '0;
            act_align_q  <= EDGE;
            pwm_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dir_down_q   <= dir_down_d;
            pend_duty_q  <= pend_duty_d;
            pend_freq_q  <= pend_freq_d;
            pend_align_q <= pend_align_d;
            act_duty_q   <= act_duty_d;
            act_freq_q   <= act_freq_d;
            act_align_q  <= act_align_d;
            pwm_q        <= pwm_d;
        end
    end

    assign pwm_output = pwm_q;
    assign period_end = boundary;
    assign busy       = running;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel: period lengths, per-channel high counts,
// double-buffered loads, center mode, drain/stop and mid-run reset.
`timescale 1ns/1ps
module tb_pwm_multi_channel;
    import pwm_pkg::*;

    localparam int WL = 8;
    localparam int FL = 2;
    localparam int CH = 4;

    logic             clk = 1'b0;
    logic             reset, start, center_align, load;
    logic [CH*WL-1:0] dutyCycle;
    logic [FL-1:0]    frequency;
    logic [CH-1:0]    pwm_output;
    logic             period_end, busy;
    state_t           dbg_state;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];

    int            hi_cnt[CH];
    int            plen_m, run0_m, n;
    logic [CH-1:0] pe_pwm_m;

    pwm_multi_channel #(
        .WORD_LENGTH (WL),
        .FREQ_LENGTH (FL),
        .CHANNELS    (CH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .dutyCycle    (dutyCycle),
        .frequency    (frequency),
        .center_align (center_align),
        .load         (load),
        .pwm_output   (pwm_output),
        .period_end   (period_end),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic load_pulse();
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic expect_period(input int p, input int h0, input int h1, input int h2, input int h3);
        exp_q.push_back(p);
        exp_q.push_back(h0);
        exp_q.push_back(h1);
        exp_q.push_back(h2);
        exp_q.push_back(h3);
    endtask

    task automatic check_period(input string tag);
        check({tag, "_len"}, plen_m, exp_q.pop_front());
        for (int c = 0; c < CH; c++) begin
            check($sformatf("%s_hi%0d", tag, c), hi_cnt[c], exp_q.pop_front());
        end
    endtask

    // Step until period_end, then one more cycle: leaves us on the first cycle of a period.
    task automatic wait_pe(input int budget);
        int k = 0;
        while (!period_end && k < budget) begin
            step(1);
            k++;
        end
        check("wait_pe_seen", period_end, 1'b1);
        step(1);
    endtask

    // Called on the first cycle of a period. Counts pwm highs for exactly that period's
    // counter values (outputs lag the counter by one cycle). load_at >= 0 pulses load at
    // that count, load_at == -1 pulses it on the period_end cycle itself.
    task automatic run_period(input int budget, input int load_at, input logic [CH*WL-1:0] new_duty);
        int  k    = 0;
        int  cur0 = 0;
        bit  seen = 1'b0;
        bit  done = 1'b0;
        run0_m   = 0;
        pe_pwm_m = '0;
        for (int c = 0; c < CH; c++) hi_cnt[c] = 0;
        while (!done && k < budget) begin
            if (k == load_at) begin
                dutyCycle = new_duty;
                load      = 1'b1;
            end
            step(1);
            load = 1'b0;
            k++;
            for (int c = 0; c < CH; c++) if (pwm_output[c]) hi_cnt[c]++;
            if (pwm_output[0]) begin
                cur0++;
                if (cur0 > run0_m) run0_m = cur0;
            end else begin
                cur0 = 0;
            end
            if (seen) begin
                done = 1'b1;
            end else if (period_end) begin
                seen     = 1'b1;
                pe_pwm_m = pwm_output;
                if (load_at == -1) begin
                    dutyCycle = new_duty;
                    load      = 1'b1;
                end
            end
        end
        plen_m = done ? k : 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset        = 1'b1;
        start        = 1'b1;
        load         = 1'b0;
        dutyCycle    = '0;
        frequency    = '0;
        center_align = 1'b0;

        // Reset with start held
        step(2);
        check("rst_pwm", pwm_output, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_pe", period_end, 1'b0);
        check("rst_state", dbg_state, IDLE);
        reset = 1'b0;
        step(1);
        check("rel_busy", busy, 1'b1);
        check("rel_state", dbg_state, RUN);
        check("rel_pwm", pwm_output, 4'b0000);
        check("rel_pe", period_end, 1'b0);

        // Edge mode, f=0
        dutyCycle = {8'd128, 8'd255, 8'd0, 8'd15};
        load_pulse();
        wait_pe(600);
        run_period(600, -2, '0);
        expect_period(256, 15, 0, 255, 128);
        check_period("edge_f0_a");
        check("edge_f0_pe_pwm", pe_pwm_m, 4'b0100);
        run_period(600, -2, '0);
        expect_period(256, 15, 0, 255, 128);
        check_period("edge_f0_b");

        // Edge mode, f=1
        frequency = 2'd1;
        load_pulse();
        wait_pe(600);
        run_period(1200, -2, '0);
        expect_period(512, 30, 0, 510, 256);
        check_period("edge_f1");
        check("edge_f1_ch0_run", run0_m, 30);

        // Double buffering: load mid-period, then load on the boundary cycle
        frequency = 2'd0;
        load_pulse();
        wait_pe(1200);
        run_period(600, 40, {8'd128, 8'd255, 8'd0, 8'd64});
        check("ld_mid_cur_len", plen_m, 256);
        check("ld_mid_cur_ch0", hi_cnt[0], 15);
        run_period(600, -1, {8'd128, 8'd255, 8'd0, 8'd100});
        check("ld_mid_next_len", plen_m, 256);
        check("ld_mid_next_ch0", hi_cnt[0], 64);
        run_period(600, -2, '0);
        expect_period(256, 100, 0, 255, 128);
        check_period("ld_bnd");

        // Center mode, f=0
        center_align = 1'b1;
        dutyCycle    = {8'd128, 8'd255, 8'd0, 8'd10};
        load_pulse();
        wait_pe(600);
        run_period(1200, -2, '0);
        expect_period(510, 19, 0, 509, 255);
        check_period("ctr_a");
        check("ctr_pe_pwm", pe_pwm_m, 4'b1101);
        check("ctr_after_pe_ch0", pwm_output[0], 1'b1);
        run_period(1200, -2, '0);
        check("ctr_b_len", plen_m, 510);
        check("ctr_b_ch0", hi_cnt[0], 19);

        // Stop, re-raise while draining
        center_align = 1'b0;
        dutyCycle    = {8'd15, 8'd0, 8'd255, 8'd128};
        load_pulse();
        wait_pe(1200);
        step(100);
        start = 1'b0;
        step(1);
        check("drain_state", dbg_state, DRAIN);
        check("drain_busy", busy, 1'b1);
        step(20);
        start = 1'b1;
        step(1);
        check("rerun_state", dbg_state, RUN);
        n = 0;
        while (!period_end && n < 600) begin
            step(1);
            n++;
        end
        check("rerun_no_restart", n, 133);

        // Stop for real: drain to the boundary then go idle
        step(1);
        step(100);
        start = 1'b0;
        n = 0;
        while (!period_end && n < 600) begin
            step(1);
            n++;
        end
        check("stop_cycles", n, 155);
        check("stop_pe_busy", busy, 1'b1);
        check("stop_pe_pwm", pwm_output, 4'b0010);
        step(1);
        check("stop_idle_state", dbg_state, IDLE);
        check("stop_idle_busy", busy, 1'b0);
        check("stop_idle_pwm", pwm_output, 4'b0000);
        check("stop_idle_pe", period_end, 1'b0);
        step(5);
        check("stop_hold_pwm", pwm_output, 4'b0000);
        check("stop_hold_busy", busy, 1'b0);

        // Restart then reset mid-run
        start = 1'b1;
        step(1);
        check("restart_busy", busy, 1'b1);
        step(50);
        check("midrun_pwm", pwm_output, 4'b0011);
        reset = 1'b1;
        step(1);
        check("rst_mid_pwm", pwm_output, 4'b0000);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_state", dbg_state, IDLE);
        check("rst_mid_pe", period_end, 1'b0);
        reset = 1'b0;
        step(3);
        check("post_rst_busy", busy, 1'b1);
        check("post_rst_pwm", pwm_output, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
